// File: rtl/matrix_frame_sequencer_if.sv
// Strip word stream between the frame sequencer and the bit-level shifter.
//   word_data  : 32-bit strip word
//   word_valid : word_data is valid; held until accepted
//   word_ready : shifter accepts the word this cycle
//   word_last  : marks the final end-frame word
interface matrix_frame_sequencer_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;

  modport master (output word_data, output word_valid, output word_last, input word_ready);
  modport slave  (input word_data, input word_valid, input word_last, output word_ready);
endinterface

// File: rtl/matrix_frame_sequencer.sv
// Sequences full 8x8 glyph frames for the LED strip serializer: walks glyph_idx
// through the font ROM, latches glyph + colours at frame start, emits a zero start
// word, 64 serpentine-ordered pixel words and END_WORDS zero end words, then dwells.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   enable            : run request (level); a started frame always completes
//   glyph_idx         : registered ROM address
//   glyph_bits        : ROM data for glyph_idx (bit 63 = row 0, col 0)
//   fg_color/bg_color : strip words for lit / unlit pixels
//   frame_done        : one-cycle pulse after the last end word is accepted
//   busy              : high whenever the sequencer is not idle
//   word_if           : valid/ready word stream to the serializer
module matrix_frame_sequencer #(
  parameter int unsigned NUM_GLYPHS   = 26,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned END_WORDS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [4:0]  glyph_idx,
  input  logic [63:0] glyph_bits,
  input  logic [31:0] fg_color,
  input  logic [31:0] bg_color,
  output logic        frame_done,
  output logic        busy,
  matrix_frame_sequencer_if.master word_if
);

  localparam int unsigned EW = $clog2(END_WORDS + 1);
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PIX, S_END, S_DWELL} state_t;

  state_t        state, state_d;
  logic [4:0]    glyph_idx_d;
  logic [63:0]   glyph_q, glyph_q_d;
  logic [31:0]   fg_q, fg_q_d, bg_q, bg_q_d;
  logic [5:0]    pix, pix_d;
  logic [EW-1:0] e_cnt, e_cnt_d;
  logic [DW-1:0] dwell, dwell_d;
  logic [31:0]   data_d;
  logic          valid_d, last_d, frame_done_d;
  logic          xfer;

  // Even rows run right-to-left through the glyph row; odd rows left-to-right.
  function automatic logic [31:0] pix_word(input logic [5:0] p, input logic [63:0] g,
                                           input logic [31:0] fg, input logic [31:0] bg);
    logic [5:0] idx;
    logic [5:0] bit_pos;
    idx     = p[3] ? p : {p[5:3], 3'd7 - p[2:0]};
    bit_pos = 6'd63 - idx;
    return g[bit_pos] ? fg : bg;
  endfunction

  assign xfer = word_if.word_valid && word_if.word_ready;

  always_comb begin
    state_d      = state;
    glyph_idx_d  = glyph_idx;
    glyph_q_d    = glyph_q;
    fg_q_d       = fg_q;
    bg_q_d       = bg_q;
    pix_d        = pix;
    e_cnt_d      = e_cnt;
    dwell_d      = dwell;
    data_d       = word_if.word_data;
    valid_d      = word_if.word_valid;
    last_d       = word_if.word_last;
    frame_done_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_START;
          glyph_q_d = glyph_bits;
          fg_q_d    = fg_color;
          bg_q_d    = bg_color;
          data_d    = '0;
          valid_d   = 1'b1;
          last_d    = 1'b0;
        end
      end
      S_START: begin
        if (xfer) begin
          state_d = S_PIX;
          pix_d   = '0;
          data_d  = pix_word(6'd0, glyph_q, fg_q, bg_q);
        end
      end
      S_PIX: begin
        if (xfer) begin
          if (pix == 6'd63) begin
            state_d = S_END;
            e_cnt_d = '0;
            data_d  = '0;
            last_d  = (END_WORDS == 1);
          end else begin
            pix_d  = pix + 6'd1;
            data_d = pix_word(pix + 6'd1, glyph_q, fg_q, bg_q);
          end
        end
      end
      S_END: begin
        if (xfer) begin
          if (e_cnt == EW'(END_WORDS - 1)) begin
            state_d      = S_DWELL;
            valid_d      = 1'b0;
            last_d       = 1'b0;
            frame_done_d = 1'b1;
            e_cnt_d      = '0;
            dwell_d      = DW'(DWELL_CYCLES);
          end else begin
            e_cnt_d = e_cnt + EW'(1);
            last_d  = ((e_cnt + EW'(1)) == EW'(END_WORDS - 1));
          end
        end
      end
      S_DWELL: begin
        // DWELL_CYCLES counted cycles advance glyph_idx; one further cycle lets the
        // ROM settle on the new address before it is latched on START entry.
        if (dwell != '0) begin
          dwell_d = dwell - DW'(1);
          if (dwell == DW'(1))
            glyph_idx_d = (glyph_idx == 5'(NUM_GLYPHS - 1)) ? 5'd0 : glyph_idx + 5'd1;
        end else if (enable) begin
          state_d   = S_START;
          glyph_q_d = glyph_bits;
          fg_q_d    = fg_color;
          bg_q_d    = bg_color;
          data_d    = '0;
          valid_d   = 1'b1;
          last_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      glyph_idx          <= '0;
      glyph_q            <= '0;
      fg_q               <= '0;
      bg_q               <= '0;
      pix                <= '0;
      e_cnt              <= '0;
      dwell              <= '0;
      word_if.word_data  <= '0;
      word_if.word_valid <= 1'b0;
      word_if.word_last  <= 1'b0;
      frame_done         <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_d;
      glyph_idx          <= glyph_idx_d;
      glyph_q            <= glyph_q_d;
      fg_q               <= fg_q_d;
      bg_q               <= bg_q_d;
      pix                <= pix_d;
      e_cnt              <= e_cnt_d;
      dwell              <= dwell_d;
      word_if.word_data  <= data_d;
      word_if.word_valid <= valid_d;
      word_if.word_last  <= last_d;
      frame_done         <= frame_done_d;
      busy               <= (state_d != S_IDLE);
    end
  end

endmodule
